// File: rtl/par_to_ser_tx.sv
// Transmit serializer on the 8f bit clock: loads one word per word period
// (sync commas after reset, then upstream data or idle fill) and shifts it out MSB first.
module par_to_ser_tx #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = 8'hBC,
  parameter int              SYNC_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             frame_out,
  output logic             active_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       LAST_SYNC = 8'(SYNC_COUNT - 1);

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift_reg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [7:0]       r_idle_cnt;
  logic             r_loaded;

  state_t           w_next_state;
  logic [WIDTH-1:0] w_next_shift;
  logic [CNT_W-1:0] w_next_cnt;
  logic [7:0]       w_next_idle;
  logic             w_load;

  assign w_load = (r_bit_cnt == LAST_BIT);

  // NOTE: every signal gets a default before any branch so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_shift = r_shift_reg << 1;
    w_next_cnt   = r_bit_cnt + 1'b1;
    w_next_idle  = r_idle_cnt;
    if (w_load) begin
      w_next_cnt = '0;
      unique case (r_state)
        SYNC: begin
          w_next_shift = IDLE_WORD;
          if (r_idle_cnt == LAST_SYNC) begin
            w_next_state = ACTIVE;
          end else begin
            w_next_idle = r_idle_cnt + 8'd1;
          end
        end
        ACTIVE: begin
          // Idle fill is per word slot: a missing word becomes one whole comma.
          w_next_shift = valid_in ? data_in : IDLE_WORD;
        end
        default: w_next_shift = IDLE_WORD;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the pre-edge values of one another, independent of statement order.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= SYNC;
      r_shift_reg <= '0;
      r_bit_cnt   <= LAST_BIT;
      r_idle_cnt  <= '0;
      r_loaded    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_shift_reg <= w_next_shift;
      r_bit_cnt   <= w_next_cnt;
      r_idle_cnt  <= w_next_idle;
      if (w_load) r_loaded <= 1'b1;
    end
  end

  assign data_out   = r_shift_reg[WIDTH-1];
  assign frame_out  = (r_bit_cnt == '0) && r_loaded;
  assign ready_out  = (r_state == ACTIVE) && w_load;
  assign active_out = (r_state == ACTIVE);

endmodule
